// File: rtl/load_store_unit.sv
// Load/store unit: byte/halfword/word accesses to a word-wide data memory with a 2-cycle read,
// sub-word stores done as read-modify-write, misaligned/illegal accesses rejected in one cycle.
//   state | meaning
//   IDLE  | waiting for req; mem_addr parked at 0
//   RD1   | memory read issued
//   RD2   | memory read in flight
//   CAP   | mem_rdData valid; captured on exit
//   WR    | memory write strobe
//   DONE  | one-cycle completion, err qualifies it
module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wrData,
    output logic              mem_rdMem,
    output logic              mem_wrMem,
    input  logic [31:0]       mem_rdData
);

    typedef enum logic [2:0] {IDLE, RD1, RD2, CAP, WR, DONE} state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic [1:0]          off_q, off_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                bad_q, bad_d;
    logic [31:0]         cap_q, cap_d;
    logic [31:0]         rdata_q, rdata_d;

    logic                bad_req;
    logic [7:0]          byte_sel;
    logic [15:0]         half_sel;
    logic [31:0]         load_ext;
    logic [31:0]         merged;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            off_q   <= 2'b00;
            waddr_q <= '0;
            wdata_q <= '0;
            bad_q   <= 1'b0;
            cap_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            bad_q   <= bad_d;
            cap_q   <= cap_d;
            rdata_q <= rdata_d;
        end
    end

    // Lane extraction from the word arriving in CAP, and lane merge for the RMW write-back.
    always_comb begin
        byte_sel = mem_rdData[{off_q, 3'b000} +: 8];
        half_sel = mem_rdData[{off_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   load_ext = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_ext = {{16{~uns_q & half_sel[15]}}, half_sel};
            default: load_ext = mem_rdData;
        endcase
        merged = cap_q;
        case (size_q)
            2'b00:   merged[{off_q, 3'b000} +: 8]     = wdata_q[7:0];
            2'b01:   merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        off_d   = off_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        bad_d   = bad_q;
        cap_d   = cap_q;
        rdata_d = rdata_q;
        bad_req = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
                  (size == 2'b10 && addr[1:0] != 2'b00);
        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    size_d  = size;
                    uns_d   = uns;
                    off_d   = addr[1:0];
                    waddr_d = {addr[ADDR_W-1:2], 2'b00};
                    wdata_d = wdata;
                    bad_d   = bad_req;
                    if (bad_req)
                        state_d = DONE;
                    else if (we && size == 2'b10)
                        state_d = WR;
                    else
                        state_d = RD1;
                end
            end
            RD1: state_d = RD2;
            RD2: state_d = CAP;
            CAP: begin
                cap_d = mem_rdData;
                if (!we_q)
                    rdata_d = load_ext;
                state_d = we_q ? WR : DONE;
            end
            WR:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign rdata      = rdata_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign err        = (state_q == DONE) && bad_q;
    assign mem_addr   = (state_q == IDLE) ? '0 : waddr_q;
    assign mem_rdMem  = (state_q == RD1) || (state_q == RD2) || (state_q == CAP);
    assign mem_wrMem  = (state_q == WR);
    assign mem_wrData = (state_q == WR) ? merged : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed corner cases plus random accesses
// checked against a byte-array memory model and a latency/strobe model.
module tb_load_store_unit;

    logic        clk, reset, req, we, uns;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rdata, mem_addr, mem_wrData, mem_rdData;
    logic        busy, done, err, mem_rdMem, mem_wrMem;

    logic [31:0] dmem [0:255];
    logic [31:0] rd_pipe;
    logic [7:0]  rmem [0:1023];
    logic [31:0] exp_rdata;
    int          n_cmp, n_err, n_rd, n_wr, n_done;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .uns(uns),
        .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .err(err),
        .mem_addr(mem_addr), .mem_wrData(mem_wrData), .mem_rdMem(mem_rdMem),
        .mem_wrMem(mem_wrMem), .mem_rdData(mem_rdData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory with two-cycle read latency: data valid in the third strobed cycle.
    always @(posedge clk) begin
        if (mem_wrMem) dmem[mem_addr[9:2]] <= mem_wrData;
        if (mem_rdMem) rd_pipe <= dmem[mem_addr[9:2]];
        mem_rdData <= rd_pipe;
    end

    always @(posedge clk) begin
        if (mem_rdMem) n_rd++;
        if (mem_wrMem) n_wr++;
        if (done)      n_done++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic u, input logic [31:0] a);
        int     nb;
        longint v;
        nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        v  = 0;
        for (int i = 0; i < nb; i++)
            v += longint'(rmem[(int'(a[9:0]) + i) & 1023]) << (8 * i);
        if (!u && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
            v -= (longint'(1) << (8 * nb));
        return 32'(v);
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int nb;
        nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        for (int i = 0; i < nb; i++)
            rmem[(int'(a[9:0]) + i) & 1023] = 8'(wd >> (8 * i));
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        dmem[a[9:2]] = v;
        ref_store(2'b10, {a[31:2], 2'b00}, v);
    endtask

    task automatic access(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd, input bit poke,
                          input string tag);
        int          exp_lat, exp_rd, n, rd0, wr0;
        logic        bad;
        logic [31:0] wa;
        bad     = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        exp_lat = bad ? 1 : !w ? 4 : (sz == 2'b10) ? 2 : 5;
        exp_rd  = (bad || (w && sz == 2'b10)) ? 0 : 3;
        wa      = {a[31:2], 2'b00};
        @(negedge clk);
        req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = wd;
        chk({tag, ".idle_addr"}, mem_addr, 32'h0);
        rd0 = n_rd; wr0 = n_wr; n = 0;
        while (n < 12) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            req = 1'b0; addr = a; we = w;
            if (done) break;
            chk({tag, ".busy"}, {31'b0, busy}, 32'h1);
            chk({tag, ".maddr"}, mem_addr, wa);
            if (poke && n == 1) begin
                req = 1'b1; addr = a ^ 32'h40; we = ~w;
            end
        end
        chk({tag, ".latency"}, 32'(n), 32'(exp_lat));
        chk({tag, ".err"}, {31'b0, err}, {31'b0, bad});
        chk({tag, ".rd_strobes"}, 32'(n_rd - rd0), 32'(exp_rd));
        chk({tag, ".wr_strobes"}, 32'(n_wr - wr0), 32'((w && !bad) ? 1 : 0));
        if (!bad && w)  ref_store(sz, a, wd);
        if (!bad && !w) exp_rdata = ref_load(sz, u, a);
        chk({tag, ".rdata"}, rdata, exp_rdata);
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".idle_busy"}, {30'b0, busy, done}, 32'h0);
        if (w || bad) chk({tag, ".mem"}, dmem[a[9:2]], ref_load(2'b10, 1'b1, wa));
    endtask

    initial begin
        int d0;
        n_cmp = 0; n_err = 0; n_rd = 0; n_wr = 0; n_done = 0;
        req = 0; we = 0; size = 0; uns = 0; addr = 0; wdata = 0; reset = 1'b1;
        rd_pipe = 0; mem_rdData = 0;
        for (int i = 0; i < 256; i++) preload(32'(i * 4), $urandom);
        exp_rdata = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.rdata", rdata, 32'h0);
        chk("rst.flags", {27'b0, busy, done, err, mem_rdMem, mem_wrMem}, 32'h0);
        chk("rst.maddr", mem_addr, 32'h0);
        reset = 1'b0;

        access(1, 2'b10, 0, 32'h0, 32'h12345678, 0, "st_word");
        access(0, 2'b10, 0, 32'h0, 32'h0, 0, "ld_word");
        chk("word_rt", rdata, 32'h12345678);

        preload(32'h4, 32'hAABBCCDD);
        access(1, 2'b00, 0, 32'h5, 32'h00000011, 0, "st_byte");
        access(0, 2'b10, 0, 32'h4, 32'h0, 0, "ld_rmw");
        chk("rmw", rdata, 32'hAABB11DD);

        preload(32'h8, 32'h80FF7F01);
        access(0, 2'b00, 0, 32'hA, 32'h0, 0, "ld_sb");
        chk("sext_b", rdata, 32'hFFFFFFFF);
        access(0, 2'b01, 1, 32'hA, 32'h0, 0, "ld_uh");
        chk("zext_h", rdata, 32'h000080FF);
        access(0, 2'b01, 0, 32'h8, 32'h0, 0, "ld_sh");
        chk("sext_h", rdata, 32'h00007F01);

        access(0, 2'b10, 0, 32'h2, 32'h0, 0, "bad_lw");
        access(1, 2'b01, 0, 32'h3, 32'hDEAD, 0, "bad_sh");
        access(1, 2'b11, 0, 32'h10, 32'hBEEF, 0, "bad_sz");
        chk("bad_keep", rdata, 32'h00007F01);

        access(0, 2'b10, 0, 32'h8, 32'h0, 1, "busy_req");
        chk("busy_req_data", rdata, 32'h80FF7F01);

        // Reset while the load sits in RD2: abandoned, no done pulse.
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h4;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        d0 = n_done;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_rdata = 32'h0;
        chk("rst_rd2.rdata", rdata, 32'h0);
        chk("rst_rd2.flags", {28'b0, busy, done, mem_rdMem, mem_wrMem}, 32'h0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_rd2.no_done", 32'(n_done - d0), 32'h0);

        // Reset while in WR: the write still lands.
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'hC; wdata = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        d0 = n_done;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        ref_store(2'b10, 32'hC, 32'hCAFEF00D);
        chk("rst_wr.mem", dmem[3], 32'hCAFEF00D);
        chk("rst_wr.flags", {29'b0, busy, done, mem_wrMem}, 32'h0);
        chk("rst_wr.no_done", 32'(n_done - d0), 32'h0);

        for (int k = 0; k < 300; k++) begin
            access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   32'($urandom_range(0, 255)), $urandom, bit'($urandom_range(0, 3) == 0), "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the byte-address width on both the CPU side and the memory side.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port req, input, 1 bit: access request, sampled only in IDLE.
REQ-005 SHALL have port we, input, 1 bit: 1 = store, 0 = load.
REQ-006 SHALL have port size, input, 2 bits: 00 = byte, 01 = halfword, 10 = word, 11 = illegal.
REQ-007 SHALL have port uns, input, 1 bit: 1 = zero-extend a sub-word load, 0 = sign-extend.
REQ-008 SHALL have port addr, input, ADDR_W bits: byte address.
REQ-009 SHALL have port wdata, input, 32 bits: store data, right-aligned.
REQ-010 SHALL have port rdata, output, 32 bits: extended load result, registered.
REQ-011 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-013 SHALL have port err, output, 1 bit: qualifies done; misaligned or illegal access.
REQ-014 SHALL have ports addr, wrData, rdMem, wrMem (outputs, widths ADDR_W/32/1/1) and rdData (input, 32 bits), named mem_addr, mem_wrData, mem_rdMem, mem_wrMem and mem_rdData, connecting to data memory.

Function
REQ-015 SHALL implement states IDLE, RD1, RD2, CAP, WR, DONE.
REQ-016 SHALL, in IDLE with req=1, latch we, size, uns, addr[1:0], word address {addr[ADDR_W-1:2],2'b00} and wdata.
REQ-017 SHALL flag an access as bad when size=11, or size=01 with addr[0]=1, or size=10 with addr[1:0]!=00.
REQ-018 SHALL route a bad access IDLE->DONE with err=1, issue no memory strobe, and leave rdata unchanged.
REQ-019 SHALL route a good load IDLE->RD1->RD2->CAP->DONE, so that done is high exactly 4 edges after the accepting edge.
REQ-020 SHALL route a good word store IDLE->WR->DONE.
REQ-021 SHALL route a good byte or halfword store IDLE->RD1->RD2->CAP->WR->DONE (read-modify-write).
REQ-022 SHALL drive mem_rdMem=1 in RD1, RD2 and CAP only, and mem_wrMem=1 in WR only; both are decodes of the state register.
REQ-023 SHALL hold mem_addr at the latched word address in every state other than IDLE; in IDLE, mem_addr SHALL be 0.
REQ-024 SHALL treat mem_rdData as valid during CAP (two-cycle memory read latency) and register it at the CAP exit edge.
REQ-025 SHALL use little-endian lanes: byte n = bits [8n+7:8n], halfword at offset 2 = bits [31:16].
REQ-026 SHALL, on a load, select the lane by the latched addr[1:0] and size, extend it per uns, and write rdata at the CAP->DONE edge.
REQ-027 SHALL, on a sub-word store, drive mem_wrData in WR as the captured word with only the addressed lane replaced by wdata[7:0] or wdata[15:0]; on a word store, mem_wrData = wdata.
REQ-028 SHALL assert done=1 only in DONE, for exactly one cycle; DONE->IDLE is unconditional.
REQ-029 SHALL drive err in DONE only, and 0 otherwise.
REQ-030 SHALL ignore req while busy, and SHALL sample req again on the DONE->IDLE edge + 1 cycle, i.e. in IDLE.
REQ-031 SHALL give back-to-back throughput of one access per (path length + 1) cycles; no pipelining.
REQ-032 SHALL hold rdata between loads; stores and errors SHALL NOT modify it.

Reset
REQ-033 SHALL, on a reset edge, force state=IDLE, rdata=0, done=0, err=0 and clear all latched request fields.
REQ-034 SHALL give reset precedence over req and every transition; an access in flight is abandoned with no done pulse.
REQ-035 SHALL still present mem_wrMem=1 on an edge where reset is asserted in WR, since the strobe is a state decode; that write SHALL commit.
REQ-036 SHALL drive busy=0, mem_rdMem=0 and mem_wrMem=0 in the cycle after a reset edge.

Verification
REQ-037 SHALL cover a word store then load: store 0x12345678 @0x0, load word @0x0 -> done 4 edges after accept, rdata=0x12345678, err=0.
REQ-038 SHALL cover a byte RMW: memory @0x4 = 0xAABBCCDD; store byte 0x11 @0x5; load word @0x4 -> 0xAABB11DD.
REQ-039 SHALL cover sign extension: memory @0x8 = 0x80FF7F01; signed byte @0xA -> 0xFFFFFFFF; unsigned halfword @0xA -> 0x000080FF; signed halfword @0x8 -> 0x00007F01.
REQ-040 SHALL cover misalignment: word load @0x2, halfword store @0x3, size=11 -> each gives done with err=1 in 1 cycle, no mem strobes, memory unchanged.
REQ-041 SHALL cover reset mid-load: reset asserted in RD2 -> IDLE next cycle, rdata=0, no done, busy=0.
REQ-042 SHALL cover a busy request: req pulsed with a different addr during RD1 -> ignored, original load completes with correct data.
